// File: rtl/avalon_mm_read_agent_mem_if.sv
// Avalon-MM read bus bundle shared by a Host and an Agent.
// Carries address/byteenable/read towards the Agent and waitrequest/data/valid back to the Host.
interface avalon_mm_read_agent_mem_if;
    logic [31:0] address;
    logic [3:0]  byteenable;
    logic        read;
    logic        waitrequest;
    logic [31:0] agent_to_host;
    logic        readdatavalid;

    modport agent (
        input  address, byteenable, read,
        output waitrequest, agent_to_host, readdatavalid
    );

    modport host (
        output address, byteenable, read,
        input  waitrequest, agent_to_host, readdatavalid
    );

    modport slave (
        input  address, byteenable, read,
        output waitrequest, agent_to_host, readdatavalid
    );

    modport master (
        output address, byteenable, read,
        input  waitrequest, agent_to_host, readdatavalid
    );
endinterface

// File: rtl/avalon_mm_read_agent_mem.sv
// Word-addressed Avalon-MM read agent backed by a loader-filled memory.
// Reads are accepted after WAIT_STATES waitrequest cycles and answered LATENCY cycles later,
// in order and without backpressure.
// Optional macro AVMM_RD_ERR_EN adds an rd_err response flag for misaligned or
// out-of-range addresses; such reads return 32'hDEAD_BEEF.
module avalon_mm_read_agent_mem #(
    parameter int unsigned DEPTH       = 1024,
    parameter int unsigned WAIT_STATES = 0,
    parameter int unsigned LATENCY     = 1
) (
    input  logic                     clk,
    input  logic                     reset,
    avalon_mm_read_agent_mem_if.agent bus,
    input  logic                     ld_we,
    input  logic [$clog2(DEPTH)-1:0] ld_addr,
    input  logic [31:0]              ld_data
`ifdef AVMM_RD_ERR_EN
    ,
    output logic                     rd_err
`endif
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam logic [3:0]  WS = 4'(WAIT_STATES);

    logic [3:0]         wcnt_q;
    logic [3:0]         wcnt_d;
    logic               accept;
    logic [AW-1:0]      rd_idx;
    logic [31:0]        mem [DEPTH];
    logic [31:0]        be_mask;
    logic [31:0]        stage0_data;
    logic [LATENCY-1:0] vld_q;
    logic [31:0]        dat_q [LATENCY];

    assign rd_idx = bus.address[AW+1:2];

`ifdef AVMM_RD_ERR_EN
    logic               addr_err;
    logic [LATENCY-1:0] err_q;

    assign addr_err = (bus.address[1:0] != 2'b00) || ((bus.address >> (AW + 2)) != 32'd0);
`else
    // Byte offset and upper address bits are deliberately ignored in this build.
    logic unused_addr;
    assign unused_addr = ^{bus.address[1:0], (bus.address >> (AW + 2))};
`endif

    // Wait-state handshake: hold the Host off until the counter reaches WAIT_STATES.
    always_comb begin
        bus.waitrequest = 1'b1;
        if (!reset) begin
            bus.waitrequest = bus.read && (wcnt_q != WS);
        end
        accept = bus.read && !bus.waitrequest;
    end

    // Counter advances only while a read is stalled; accept or an abandoned read clears it.
    always_comb begin
        wcnt_d = '0;
        if (bus.read && bus.waitrequest) begin
            wcnt_d = wcnt_q + 4'd1;
        end
    end

    // Wait-state counter register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wcnt_q <= '0;
        end else begin
            wcnt_q <= wcnt_d;
        end
    end

    // Loader port; not gated by reset so boot logic can fill memory while reset is held.
    always_ff @(posedge clk) begin
        if (ld_we) begin
            mem[ld_addr] <= ld_data;
        end
    end

    // Build the stage-1 word: byte-lane masking, or the error pattern when enabled.
    always_comb begin
        be_mask = '0;
        for (int i = 0; i < 4; i++) begin
            be_mask[8*i +: 8] = {8{bus.byteenable[i]}};
        end
        stage0_data = mem[rd_idx] & be_mask;
`ifdef AVMM_RD_ERR_EN
        if (addr_err) begin
            stage0_data = 32'hDEAD_BEEF;
        end
`endif
    end

    // Valid shift register; async reset drops every in-flight response at once.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            vld_q <= '0;
        end else begin
            vld_q[0] <= accept;
            for (int i = 1; i < LATENCY; i++) begin
                vld_q[i] <= vld_q[i-1];
            end
        end
    end

    // Data shift register; stage 0 samples memory at the edge so a same-edge load is not seen.
    always_ff @(posedge clk) begin
        dat_q[0] <= stage0_data;
        for (int i = 1; i < LATENCY; i++) begin
            dat_q[i] <= dat_q[i-1];
        end
`ifdef AVMM_RD_ERR_EN
        err_q[0] <= addr_err;
        for (int i = 1; i < LATENCY; i++) begin
            err_q[i] <= err_q[i-1];
        end
`endif
    end

    // Response outputs are forced to zero whenever no response is valid.
    always_comb begin
        bus.readdatavalid = vld_q[LATENCY-1];
        bus.agent_to_host = vld_q[LATENCY-1] ? dat_q[LATENCY-1] : 32'd0;
`ifdef AVMM_RD_ERR_EN
        rd_err = vld_q[LATENCY-1] && err_q[LATENCY-1];
`endif
    end

endmodule

// File: tb/tb_avalon_mm_read_agent_mem.sv
// Directed bench for avalon_mm_read_agent_mem.
// Four instances cover the wait-state and latency configurations; the loader is shared.
module tb_avalon_mm_read_agent_mem;

    logic        clk;
    logic        r0, r1, r2, r3;
    logic        ld_we;
    logic [9:0]  ld_addr;
    logic [31:0] ld_data;
    int          checks;
    int          errors;

    avalon_mm_read_agent_mem_if b0 ();
    avalon_mm_read_agent_mem_if b1 ();
    avalon_mm_read_agent_mem_if b2 ();
    avalon_mm_read_agent_mem_if b3 ();

`ifdef AVMM_RD_ERR_EN
    logic err0, err1, err2, err3;
`endif

    avalon_mm_read_agent_mem #(.DEPTH(1024), .WAIT_STATES(0), .LATENCY(1)) u0 (
        .clk(clk), .reset(r0), .bus(b0), .ld_we(ld_we), .ld_addr(ld_addr), .ld_data(ld_data)
`ifdef AVMM_RD_ERR_EN
        , .rd_err(err0)
`endif
    );
    avalon_mm_read_agent_mem #(.DEPTH(1024), .WAIT_STATES(2), .LATENCY(1)) u1 (
        .clk(clk), .reset(r1), .bus(b1), .ld_we(ld_we), .ld_addr(ld_addr), .ld_data(ld_data)
`ifdef AVMM_RD_ERR_EN
        , .rd_err(err1)
`endif
    );
    avalon_mm_read_agent_mem #(.DEPTH(1024), .WAIT_STATES(0), .LATENCY(3)) u2 (
        .clk(clk), .reset(r2), .bus(b2), .ld_we(ld_we), .ld_addr(ld_addr), .ld_data(ld_data)
`ifdef AVMM_RD_ERR_EN
        , .rd_err(err2)
`endif
    );
    avalon_mm_read_agent_mem #(.DEPTH(1024), .WAIT_STATES(0), .LATENCY(4)) u3 (
        .clk(clk), .reset(r3), .bus(b3), .ld_we(ld_we), .ld_addr(ld_addr), .ld_data(ld_data)
`ifdef AVMM_RD_ERR_EN
        , .rd_err(err3)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] addr;
        logic [3:0]  be;
        logic [31:0] data;
        logic        err;
    } vec_t;

    vec_t vecs [8];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    // Align to one time unit after the rising edge, where inputs change.
    task automatic to_drive();
        @(posedge clk);
        #1;
    endtask

    task automatic ld(input logic [9:0] idx, input logic [31:0] val);
        to_drive();
        ld_we   = 1'b1;
        ld_addr = idx;
        ld_data = val;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] exp_d;
        logic        exp_v;

        checks = 0;
        errors = 0;
        vecs[0] = '{32'h0000_0014, 4'hF, 32'h1234_5678, 1'b0};
        vecs[1] = '{32'h0000_001C, 4'h5, 32'h00BB_00DD, 1'b0};
        vecs[2] = '{32'h0000_1014, 4'hF, 32'h1234_5678, 1'b1};
        vecs[3] = '{32'h0000_0000, 4'hF, 32'h0000_00A0, 1'b0};
        vecs[4] = '{32'h0000_000C, 4'h3, 32'h0000_00A3, 1'b0};
        vecs[5] = '{32'h0000_001C, 4'hA, 32'hAA00_CC00, 1'b0};
        vecs[6] = '{32'h0000_0015, 4'hF, 32'h1234_5678, 1'b1};
        vecs[7] = '{32'h0000_001C, 4'h0, 32'h0000_0000, 1'b0};

        {b0.read, b1.read, b2.read, b3.read} = '0;
        {b0.address, b1.address, b2.address, b3.address} = '0;
        {b0.byteenable, b1.byteenable, b2.byteenable, b3.byteenable} = '1;
        ld_we = 1'b0; ld_addr = '0; ld_data = '0;
        {r0, r1, r2, r3} = 4'hF;

        // Reset state.
        to_drive();
        b0.read = 1'b1;
        #4;
        chk("rst_waitreq", 32'(b0.waitrequest), 32'd1);
        chk("rst_rdv0", 32'(b0.readdatavalid), 32'd0);
        chk("rst_data0", b0.agent_to_host, 32'd0);
        chk("rst_rdv1", 32'(b1.readdatavalid), 32'd0);
        chk("rst_rdv2", 32'(b2.readdatavalid), 32'd0);
        chk("rst_rdv3", 32'(b3.readdatavalid), 32'd0);
        b0.read = 1'b0;

        // Loader runs while reset is still asserted.
        ld(10'd0, 32'h0000_00A0);
        ld(10'd1, 32'h0000_00A1);
        ld(10'd2, 32'h0000_00A2);
        ld(10'd3, 32'h0000_00A3);
        ld(10'd5, 32'h1234_5678);
        ld(10'd7, 32'hAABB_CCDD);
        ld(10'd9, 32'h0000_0000);
        to_drive();
        ld_we = 1'b0;
        {r0, r1, r2, r3} = 4'h0;
        #4;
        chk("idle_waitreq", 32'(b0.waitrequest), 32'd0);

        // Table of single reads, zero wait states, latency 1.
        for (int i = 0; i < 8; i++) begin
            to_drive();
            b0.read       = 1'b1;
            b0.address    = vecs[i].addr;
            b0.byteenable = vecs[i].be;
            #4;
            chk($sformatf("vec%0d_waitreq", i), 32'(b0.waitrequest), 32'd0);
            chk($sformatf("vec%0d_idle_rdv", i), 32'(b0.readdatavalid), 32'd0);
            chk($sformatf("vec%0d_idle_data", i), b0.agent_to_host, 32'd0);
            to_drive();
            b0.read = 1'b0;
            #4;
            exp_d = vecs[i].data;
`ifdef AVMM_RD_ERR_EN
            if (vecs[i].err) exp_d = 32'hDEAD_BEEF;
            chk($sformatf("vec%0d_err", i), 32'(err0), 32'(vecs[i].err));
`endif
            chk($sformatf("vec%0d_rdv", i), 32'(b0.readdatavalid), 32'd1);
            chk($sformatf("vec%0d_data", i), b0.agent_to_host, exp_d);
        end

        // Same-edge load and read of word 9: old value comes back, then the new one.
        to_drive();
        b0.read = 1'b1; b0.address = 32'h24; b0.byteenable = 4'hF;
        ld_we = 1'b1; ld_addr = 10'd9; ld_data = 32'h1;
        to_drive();
        b0.read = 1'b0; ld_we = 1'b0;
        #4;
        chk("rbw_rdv", 32'(b0.readdatavalid), 32'd1);
        chk("rbw_old", b0.agent_to_host, 32'h0);
        to_drive();
        b0.read = 1'b1;
        to_drive();
        b0.read = 1'b0;
        #4;
        chk("rbw_new", b0.agent_to_host, 32'h1);

        // Two wait states: stall, stall, accept.
        to_drive();
        b1.read = 1'b1; b1.address = 32'h0; b1.byteenable = 4'hF;
        #4;
        chk("ws_c0", 32'(b1.waitrequest), 32'd1);
        to_drive();
        #4;
        chk("ws_c1", 32'(b1.waitrequest), 32'd1);
        chk("ws_c1_rdv", 32'(b1.readdatavalid), 32'd0);
        to_drive();
        #4;
        chk("ws_c2", 32'(b1.waitrequest), 32'd0);
        to_drive();
        b1.read = 1'b0;
        #4;
        chk("ws_rdv", 32'(b1.readdatavalid), 32'd1);
        chk("ws_data", b1.agent_to_host, 32'h0000_00A0);
        to_drive();
        #4;
        chk("ws_rdv_once", 32'(b1.readdatavalid), 32'd0);

        // Abandoned read: no response, and the next read waits the full count again.
        to_drive();
        b1.read = 1'b1; b1.address = 32'h14;
        #4;
        chk("abn_wait", 32'(b1.waitrequest), 32'd1);
        to_drive();
        b1.read = 1'b0;
        #4;
        chk("abn_wr_low", 32'(b1.waitrequest), 32'd0);
        chk("abn_no_rdv", 32'(b1.readdatavalid), 32'd0);
        to_drive();
        b1.read = 1'b1; b1.address = 32'h1C;
        #4;
        chk("abn_c0", 32'(b1.waitrequest), 32'd1);
        to_drive();
        #4;
        chk("abn_c1", 32'(b1.waitrequest), 32'd1);
        to_drive();
        #4;
        chk("abn_c2", 32'(b1.waitrequest), 32'd0);
        chk("abn_c2_rdv", 32'(b1.readdatavalid), 32'd0);
        to_drive();
        b1.read = 1'b0;
        #4;
        chk("abn_rdv", 32'(b1.readdatavalid), 32'd1);
        chk("abn_data", b1.agent_to_host, 32'hAABB_CCDD);

        // Latency 3, four back-to-back reads of words 0..3.
        for (int c = 0; c < 8; c++) begin
            to_drive();
            if (c < 4) begin
                b2.read = 1'b1; b2.address = 32'(c * 4); b2.byteenable = 4'hF;
            end else begin
                b2.read = 1'b0;
            end
            #4;
            if (c < 4) chk($sformatf("l3_wr%0d", c), 32'(b2.waitrequest), 32'd0);
            exp_v = (c >= 3) && (c <= 6);
            exp_d = exp_v ? 32'(32'hA0 + c - 3) : 32'd0;
            chk($sformatf("l3_rdv%0d", c), 32'(b2.readdatavalid), 32'(exp_v));
            chk($sformatf("l3_data%0d", c), b2.agent_to_host, exp_d);
        end

        // Latency 4: reset after two accepts discards both; a word loaded alongside survives.
        to_drive();
        b3.read = 1'b1; b3.address = 32'h0; b3.byteenable = 4'hF;
        ld_we = 1'b1; ld_addr = 10'd12; ld_data = 32'hCAFE_F00D;
        to_drive();
        b3.address = 32'h4; ld_we = 1'b0;
        to_drive();
        b3.read = 1'b0; r3 = 1'b1;
        #4;
        chk("rst4_rdv_a", 32'(b3.readdatavalid), 32'd0);
        to_drive();
        #4;
        chk("rst4_rdv_b", 32'(b3.readdatavalid), 32'd0);
        for (int c = 0; c < 6; c++) begin
            to_drive();
            if (c == 0) r3 = 1'b0;
            #4;
            chk($sformatf("rst4_after%0d", c), 32'(b3.readdatavalid), 32'd0);
        end
        to_drive();
        b3.read = 1'b1; b3.address = 32'h30;
        for (int k = 1; k <= 4; k++) begin
            to_drive();
            if (k == 1) b3.read = 1'b0;
            #4;
            chk($sformatf("rst4_rd%0d", k), 32'(b3.readdatavalid), 32'(k == 4));
            if (k == 4) chk("rst4_data", b3.agent_to_host, 32'hCAFE_F00D);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
